frac_logic_ccff_loader: RTL and testbench

//  Sequences the configuration-chain (ccff) programming of a frac_logic / fle tile chain.

---
 rtl/frac_logic_ccff_loader_pkg.sv | 15 +
 rtl/frac_logic_ccff_loader_if.sv | 23 ++
 rtl/frac_logic_ccff_loader_ser.sv | 40 ++++
 rtl/frac_logic_ccff_loader.sv | 138 +++++++++++++
 tb/tb_frac_logic_ccff_loader.sv | 351 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/frac_logic_ccff_loader_pkg.sv
// Shared types and helpers for the frac_logic ccff chain loader.
// Package frac_cfg_pkg: loader FSM states and counter-width helper.
package frac_cfg_pkg;

   typedef enum logic [1:0] {
      IDLE,
      LOAD,
      DONE
   } ldr_state_t;

   function automatic int cnt_w(input int n);
      return $clog2(n + 1);
   endfunction

endpackage

// File: rtl/frac_logic_ccff_loader_if.sv
// Configuration word stream into the ccff chain loader.
// Master drives words, slave (the loader) returns ready.
interface frac_logic_ccff_loader_if #(
   parameter int W = 8
) ();

   logic [W-1:0] cfg_data;
   logic         cfg_valid;
   logic         cfg_ready;

   modport master (
      output cfg_data,
      output cfg_valid,
      input  cfg_ready
   );

   modport slave (
      input  cfg_data,
      input  cfg_valid,
      output cfg_ready
   );

endinterface

// File: rtl/frac_logic_ccff_loader_ser.sv
// ccff_bit_serializer: W-bit word register shifted out MSB-first.
// Tracks how many bits of the current word are still to be shifted.
module ccff_bit_serializer
   import frac_cfg_pkg::*;
#(
   parameter int W  = 8,
   parameter int BW = cnt_w(W)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          clr,
   input  logic          load,
   input  logic          shift,
   input  logic [W-1:0]  data,
   output logic          head,
   output logic [BW-1:0] bits_left
);

   logic [W-1:0] sreg;

   // clear beats load, load beats shift (a new word replaces the last bit)
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sreg      <= '0;
         bits_left <= '0;
      end else if (clr) begin
         sreg      <= '0;
         bits_left <= '0;
      end else if (load) begin
         sreg      <= data;
         bits_left <= BW'(W);
      end else if (shift) begin
         sreg      <= {sreg[W-2:0], 1'b0};
         bits_left <= bits_left - 1'b1;
      end
   end

   assign head = sreg[W-1];

endmodule

// File: rtl/frac_logic_ccff_loader.sv
// Loads a frac_logic/fle ccff chain from a word stream, MSB-first.
// Optional tail readback enabled by defining CCFF_READBACK_EN.
module frac_logic_ccff_loader
   import frac_cfg_pkg::*;
#(
   parameter int CHAIN_LEN = 21,
   parameter int W         = 8
) (
   input  logic                   prog_clk,
   input  logic                   pReset_n,
   input  logic                   start,
   input  logic                   abort,
   frac_logic_ccff_loader_if.slave cfg,
   output logic                   ccff_head,
   input  logic                   ccff_tail,
   output logic                   shift_en,
   output logic                   busy,
   output logic                   done,
   output logic [W-1:0]           rb_data,
   output logic                   rb_valid
);

   localparam int CW = cnt_w(CHAIN_LEN);
   localparam int BW = cnt_w(W);
   localparam logic [CW-1:0] LAST_BIT = CW'(CHAIN_LEN - 1);

   ldr_state_t    state;
   logic [CW-1:0] bit_cnt;
   logic [BW-1:0] bits_left;
   logic          active;
   logic          words_req;
   logic          ready;
   logic          step;
   logic          last;
   logic          ld;
   logic          clr;

   assign active    = (state == LOAD);
   assign shift_en  = active && (bits_left != '0);
   assign words_req = (32'(bit_cnt) + 32'(bits_left)) < 32'(CHAIN_LEN);
   assign ready     = active && (bits_left <= BW'(1)) && words_req;
   assign step      = shift_en && !abort;
   assign last      = step && (bit_cnt == LAST_BIT);
   assign ld        = cfg.cfg_valid && ready && !abort;
   assign clr       = (active && abort) || last;

   assign cfg.cfg_ready = ready;
   assign busy          = active;
   assign done          = (state == DONE);

   ccff_bit_serializer #(
      .W  (W),
      .BW (BW)
   ) u_ser (
      .clk       (prog_clk),
      .rst_n     (pReset_n),
      .clr       (clr),
      .load      (ld),
      .shift     (step),
      .data      (cfg.cfg_data),
      .head      (ccff_head),
      .bits_left (bits_left)
   );

   // load sequencer: abort wins, final shift ends the load
   always_ff @(posedge prog_clk) begin
      if (!pReset_n) begin
         state   <= IDLE;
         bit_cnt <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               if (start && !abort) begin
                  state   <= LOAD;
                  bit_cnt <= '0;
               end
            end
            LOAD: begin
               if (abort) begin
                  state   <= IDLE;
                  bit_cnt <= '0;
               end else if (last) begin
                  state   <= DONE;
                  bit_cnt <= '0;
               end else if (step) begin
                  bit_cnt <= bit_cnt + 1'b1;
               end
            end
            DONE: state <= IDLE;
            default: begin
               state   <= IDLE;
               bit_cnt <= '0;
            end
         endcase
      end
   end

`ifdef CCFF_READBACK_EN
   logic [W-1:0]  rb_sreg;
   logic [W-1:0]  rb_next;
   logic [BW-1:0] rb_cnt;

   assign rb_next = {rb_sreg[W-2:0], ccff_tail};

   // old chain contents arrive tail-first; emit per word, partial at end
   always_ff @(posedge prog_clk) begin
      if (!pReset_n) begin
         rb_sreg  <= '0;
         rb_cnt   <= '0;
         rb_data  <= '0;
         rb_valid <= 1'b0;
      end else begin
         rb_valid <= 1'b0;
         if (state == IDLE) begin
            rb_sreg <= '0;
            rb_cnt  <= '0;
         end else if (step) begin
            if (last || rb_cnt == BW'(W - 1)) begin
               rb_data  <= rb_next;
               rb_valid <= 1'b1;
               rb_sreg  <= '0;
               rb_cnt   <= '0;
            end else begin
               rb_sreg <= rb_next;
               rb_cnt  <= rb_cnt + 1'b1;
            end
         end
      end
   end
`else
   logic unused_tail;

   assign unused_tail = ccff_tail;
   assign rb_data     = '0;
   assign rb_valid    = 1'b0;
`endif

endmodule

// File: tb/tb_frac_logic_ccff_loader.sv
// Bench for frac_logic_ccff_loader: vector table, random words, corner cases.
// Readback checks compiled in when CCFF_READBACK_EN is defined.
module tb_frac_logic_ccff_loader;

   localparam int CL = 21;
   localparam int W  = 8;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         start = 1'b0;
   logic         abort = 1'b0;
   logic         head;
   logic         tail;
   logic         shift_en;
   logic         busy;
   logic         done;
   logic [W-1:0] rb_data;
   logic         rb_valid;

   logic         s_start = 1'b0;
   logic         s_abort = 1'b0;
   logic         s_head;
   logic         s_tail = 1'b0;
   logic         s_shift;
   logic         s_busy;
   logic         s_done;
   logic [1:0]   s_rbd;
   logic         s_rbv;

   always #5 clk = ~clk;

   frac_logic_ccff_loader_if #(.W(W)) if1 ();
   frac_logic_ccff_loader_if #(.W(2)) if2 ();

   frac_logic_ccff_loader #(.CHAIN_LEN(CL), .W(W)) dut (
      .prog_clk (clk),
      .pReset_n (rst_n),
      .start    (start),
      .abort    (abort),
      .cfg      (if1),
      .ccff_head(head),
      .ccff_tail(tail),
      .shift_en (shift_en),
      .busy     (busy),
      .done     (done),
      .rb_data  (rb_data),
      .rb_valid (rb_valid)
   );

   frac_logic_ccff_loader #(.CHAIN_LEN(1), .W(2)) dut_small (
      .prog_clk (clk),
      .pReset_n (rst_n),
      .start    (s_start),
      .abort    (s_abort),
      .cfg      (if2),
      .ccff_head(s_head),
      .ccff_tail(s_tail),
      .shift_en (s_shift),
      .busy     (s_busy),
      .done     (s_done),
      .rb_data  (s_rbd),
      .rb_valid (s_rbv)
   );

   int errors = 0;
   int checks = 0;

   task automatic check(input string nm, input logic [31:0] got,
                        input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, got, exp);
      end
   endtask

   // chain model: shifts one bit in at the head on every enabled edge
   logic [CL-1:0] chain = '0;
   always @(posedge clk)
      if (shift_en) chain <= {chain[CL-2:0], head};
   assign tail = chain[CL-1];

   // event log sampled on the falling edge
   int           cyc = 0;
   int           q_cyc[$];
   bit           q_head[$];
   int           q_done[$];
   int           n_acc = 0;
   logic [W-1:0] q_rb[$];
   int           rb_bad = 0;

   always @(negedge clk) begin
      cyc <= cyc + 1;
      if (shift_en) begin
         q_cyc.push_back(cyc);
         q_head.push_back(head);
      end
      if (done) q_done.push_back(cyc);
      if (if1.cfg_valid && if1.cfg_ready) n_acc <= n_acc + 1;
`ifdef CCFF_READBACK_EN
      if (rb_valid) q_rb.push_back(rb_data);
`else
      if (rb_valid || rb_data != '0) rb_bad <= rb_bad + 1;
`endif
   end

   typedef struct {
      logic [23:0] words;
      int          stall_word;
      int          stall_len;
      logic [20:0] exp_bits;
      int          exp_gap;
   } vec_t;

   vec_t vecs[$];

   task automatic wait_done(input int d0, input string nm);
      int t;
      for (t = 0; t < 300; t++) begin
         @(negedge clk);
         #1;
         if (q_done.size() > d0) break;
      end
      if (t >= 300) check({nm, " done_timeout"}, 1, 0);
   endtask

   task automatic run_load(input vec_t v, input string nm);
      int            sh0, d0, a0, r0, nsh, first, last, t;
      logic [CL-1:0] snap;
      logic [20:0]   got;
      logic [W-1:0]  w;
      sh0  = q_head.size();
      d0   = q_done.size();
      a0   = n_acc;
      r0   = q_rb.size();
      snap = chain;
      @(posedge clk); #1;
      start = 1'b1;
      if1.cfg_valid = 1'b1;
      if1.cfg_data  = v.words[23:16];
      @(posedge clk); #1;
      start = 1'b0;
      for (int i = 0; i < 3; i++) begin
         w = v.words[23 - 8 * i -: 8];
         if1.cfg_data  = w;
         if1.cfg_valid = 1'b1;
         for (t = 0; t < 200; t++) begin
            @(negedge clk);
            if (if1.cfg_valid && if1.cfg_ready) break;
         end
         if (t >= 200) check({nm, " accept_timeout"}, 1, 0);
         @(posedge clk); #1;
         if (i == v.stall_word) begin
            if1.cfg_valid = 1'b0;
            repeat (W - 1 + v.stall_len) @(posedge clk);
            #1;
         end
      end
      if1.cfg_data = 8'h00;
      wait_done(d0, nm);
      if1.cfg_valid = 1'b0;
      @(negedge clk); #1;
      nsh = q_head.size() - sh0;
      check({nm, " shifts"}, nsh, CL);
      got = '0;
      for (int k = 0; k < CL && k < nsh; k++)
         got = {got[19:0], q_head[sh0 + k]};
      check({nm, " head_bits"}, got, v.exp_bits);
      if (nsh > 0) begin
         first = q_cyc[sh0];
         last  = q_cyc[sh0 + nsh - 1];
         check({nm, " gap"}, last - first + 1 - nsh, v.exp_gap);
         check({nm, " done_cnt"}, q_done.size() - d0, 1);
         if (q_done.size() > d0)
            check({nm, " done_lat"}, q_done[d0], last + 1);
      end
      check({nm, " accepts"}, n_acc - a0, 3);
      check({nm, " busy_after"}, busy, 0);
`ifdef CCFF_READBACK_EN
      check({nm, " rb_cnt"}, q_rb.size() - r0, 3);
      if (q_rb.size() - r0 == 3) begin
         for (int j = 0; j < 3; j++) begin
            logic [W-1:0] e;
            int n;
            e = '0;
            n = (j < 2) ? 8 : CL - 16;
            for (int k = 0; k < n; k++)
               e = {e[W-2:0], snap[CL - 1 - (8 * j + k)]};
            check({nm, " rb_word"}, q_rb[r0 + j], e);
         end
      end
`endif
      t = r0;
   endtask

   task automatic wait_shifts(input int sh0, input int n, input string nm);
      int t;
      for (t = 0; t < 200; t++) begin
         @(negedge clk);
         #1;
         if (q_head.size() - sh0 >= n) break;
      end
      if (t >= 200) check({nm, " shift_timeout"}, 1, 0);
   endtask

   initial begin
      vec_t v;
      int   sh0, d0;
      int   ns, nd, na, sc, dc;
      logic sh;
      if1.cfg_valid = 1'b0;
      if1.cfg_data  = '0;
      if2.cfg_valid = 1'b0;
      if2.cfg_data  = '0;
      repeat (3) @(posedge clk);
      #1;
      check("rst cfg_ready", if1.cfg_ready, 0);
      check("rst ccff_head", head, 0);
      check("rst shift_en", shift_en, 0);
      check("rst busy", busy, 0);
      check("rst done", done, 0);
      check("rst rb_valid", rb_valid, 0);
      check("rst rb_data", rb_data, 0);
      rst_n = 1'b1;

      vecs.push_back('{24'hA53CF0, -1, 0, {8'hA5, 8'h3C, 5'h1E}, 0});
      vecs.push_back('{24'hA53CF0, 0, 5, {8'hA5, 8'h3C, 5'h1E}, 5});
      vecs.push_back('{24'h0F817E, 1, 3, {8'h0F, 8'h81, 5'h0F}, 3});
      vecs.push_back('{24'hFFFFFF, 0, 0, 21'h1FFFFF, 0});
      for (int i = 0; i < 6; i++) begin
         v.words      = 24'($urandom);
         v.stall_word = int'($urandom_range(0, 2)) - 1;
         v.stall_len  = int'($urandom_range(0, 6));
         v.exp_bits   = v.words[23:3];
         v.exp_gap    = (v.stall_word < 0) ? 0 : v.stall_len;
         vecs.push_back(v);
      end
      for (int i = 0; i < vecs.size(); i++)
         run_load(vecs[i], $sformatf("vec%0d", i));

      // abort at bit_cnt=10
      sh0 = q_head.size();
      d0  = q_done.size();
      @(posedge clk); #1;
      start = 1'b1;
      if1.cfg_data  = 8'h5A;
      if1.cfg_valid = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      wait_shifts(sh0, 10, "abort");
      @(posedge clk); #1;
      abort = 1'b1;
      @(posedge clk); #1;
      abort = 1'b0;
      check("abort shift_en", shift_en, 0);
      check("abort busy", busy, 0);
      check("abort ready", if1.cfg_ready, 0);
      if1.cfg_valid = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      check("abort no_done", q_done.size() - d0, 0);
      run_load(vecs[0], "restart");

      // reset mid-load at bit 15, start held during reset
      sh0 = q_head.size();
      d0  = q_done.size();
      @(posedge clk); #1;
      start = 1'b1;
      if1.cfg_data  = 8'h96;
      if1.cfg_valid = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      wait_shifts(sh0, 15, "rstmid");
      @(posedge clk); #1;
      rst_n = 1'b0;
      start = 1'b1;
      @(posedge clk); #1;
      check("rstmid cfg_ready", if1.cfg_ready, 0);
      check("rstmid ccff_head", head, 0);
      check("rstmid shift_en", shift_en, 0);
      check("rstmid busy", busy, 0);
      check("rstmid done", done, 0);
      check("rstmid rb_valid", rb_valid, 0);
      check("rstmid rb_data", rb_data, 0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      start = 1'b0;
      @(posedge clk); #1;
      check("rstmid start_ignored", busy, 0);
      check("rstmid no_done", q_done.size() - d0, 0);
      if1.cfg_valid = 1'b0;

      // start pulse during LOAD has no effect
      sh0 = q_head.size();
      d0  = q_done.size();
      @(posedge clk); #1;
      start = 1'b1;
      if1.cfg_data  = 8'hC3;
      if1.cfg_valid = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      wait_shifts(sh0, 5, "midstart");
      @(posedge clk); #1;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      wait_done(d0, "midstart");
      if1.cfg_valid = 1'b0;
      @(negedge clk); #1;
      check("midstart shifts", q_head.size() - sh0, CL);
      check("midstart done_cnt", q_done.size() - d0, 1);
      repeat (3) @(posedge clk);
      #1;
      check("midstart idle", busy, 0);

      // CHAIN_LEN=1, W=2: one shift then done
      ns = 0; nd = 0; na = 0; sc = -10; dc = -20; sh = 1'b0;
      if2.cfg_data  = 2'b10;
      if2.cfg_valid = 1'b1;
      @(posedge clk); #1;
      s_start = 1'b1;
      @(posedge clk); #1;
      s_start = 1'b0;
      for (int t = 0; t < 20; t++) begin
         @(negedge clk);
         if (s_shift) begin
            ns++;
            sc = t;
            sh = s_head;
         end
         if (s_done) begin
            nd++;
            dc = t;
         end
         if (if2.cfg_valid && if2.cfg_ready) na++;
      end
      if2.cfg_valid = 1'b0;
      check("small shifts", ns, 1);
      check("small head", sh, 1);
      check("small done_cnt", nd, 1);
      check("small done_lat", dc, sc + 1);
      check("small accepts", na, 1);

`ifndef CCFF_READBACK_EN
      check("rb_tied_zero", rb_bad, 0);
`endif
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
